// File: rtl/eeg_feat_pkg.sv
// Shared widths, derived-width helpers and FSM state type for the EEG
// windowed feature extractor.
package eeg_feat_pkg;

  localparam int SAMPLE_W = 32;
  // |x[n]-x[n-1]| needs one bit more than a sample.
  localparam int ABS_W    = SAMPLE_W + 1;
  // Full signed square of a sample.
  localparam int SQ_W     = 2 * SAMPLE_W;

  // Line-length accumulator width: one abs term per sample, 2^win_log2 samples.
  function automatic int ll_w(input int win_log2);
    return ABS_W + win_log2;
  endfunction

  // Energy accumulator width: one square term per sample, 2^win_log2 samples.
  function automatic int en_w(input int win_log2);
    return SQ_W + win_log2;
  endfunction

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } feat_state_e;

endpackage

// File: rtl/feat_term.sv
// Combinational per-sample term generator: absolute first difference and
// shifted energy term for one filtered sample.
module feat_term
  import eeg_feat_pkg::*;
#(
  parameter int ESHIFT = 16
) (
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [SAMPLE_W-1:0] i_prev,
  input  logic                i_first,
  output logic [ABS_W-1:0]    o_abs_diff,
  output logic [SQ_W-1:0]     o_en_term
);

  logic signed [ABS_W-1:0] w_diff;
  logic signed [SQ_W-1:0]  w_sx;
  logic signed [SQ_W-1:0]  w_sq;

  // 33-bit signed difference cannot overflow for any pair of 32-bit samples;
  // its magnitude tops out at 2^32-1, which still fits the unsigned 33-bit result.
  assign w_diff     = $signed({i_sample[SAMPLE_W-1], i_sample})
                    - $signed({i_prev[SAMPLE_W-1], i_prev});
  assign o_abs_diff = i_first ? '0
                    : (w_diff[ABS_W-1] ? $unsigned(-w_diff) : $unsigned(w_diff));

  // Square is non-negative, so the arithmetic shift never drags in sign bits.
  assign w_sx      = {{SAMPLE_W{i_sample[SAMPLE_W-1]}}, i_sample};
  assign w_sq      = w_sx * w_sx;
  assign o_en_term = $unsigned(w_sq >>> ESHIFT);

endmodule

// File: rtl/eeg_window_features.sv
// Windowed line-length / energy feature extractor with threshold detect and
// a single-entry valid/ready output slot. i_reset is active low.
module eeg_window_features
  import eeg_feat_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int ESHIFT   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [SAMPLE_W-1:0]       i_sample_in,
  input  logic                      i_sample_valid,
  input  logic [ABS_W+WIN_LOG2-1:0] i_ll_thresh,
  input  logic [SQ_W+WIN_LOG2-1:0]  i_en_thresh,
  output logic [ABS_W+WIN_LOG2-1:0] o_ll_out,
  output logic [SQ_W+WIN_LOG2-1:0]  o_en_out,
  output logic                      o_detect,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic                      o_overrun
);

  localparam int LL_W = ll_w(WIN_LOG2);
  localparam int EN_W = en_w(WIN_LOG2);
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  feat_state_e             r_state;
  logic [WIN_LOG2-1:0]     r_cnt;
  logic [LL_W-1:0]         r_ll_acc;
  logic [EN_W-1:0]         r_en_acc;
  logic [SAMPLE_W-1:0]     r_prev;
  logic                    r_seen;
  logic [LL_W-1:0]         r_hold_ll;
  logic [EN_W-1:0]         r_hold_en;
  logic [LL_W-1:0]         r_ll_out;
  logic [EN_W-1:0]         r_en_out;
  logic                    r_detect;
  logic                    r_out_valid;
  logic                    r_overrun;

  logic [ABS_W-1:0]        w_abs;
  logic [SQ_W-1:0]         w_en_term;
  logic [LL_W-1:0]         w_ll_sum;
  logic [EN_W-1:0]         w_en_sum;
  logic                    w_close;
  logic                    w_slot_free;

  feat_term #(
    .ESHIFT (ESHIFT)
  ) u_term (
    .i_sample   (i_sample_in),
    .i_prev     (r_prev),
    .i_first    (~r_seen),
    .o_abs_diff (w_abs),
    .o_en_term  (w_en_term)
  );

  assign w_ll_sum    = r_ll_acc + LL_W'(w_abs);
  assign w_en_sum    = r_en_acc + EN_W'(w_en_term);
  assign w_close     = i_sample_valid && (r_cnt == CNT_LAST);
  // Slot can take a new result if empty or being drained on this same edge.
  assign w_slot_free = !r_out_valid || i_out_ready;

  // Sample datapath: accumulate every accepted sample, snapshot sums at window close.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt     <= '0;
      r_ll_acc  <= '0;
      r_en_acc  <= '0;
      r_prev    <= '0;
      r_seen    <= 1'b0;
      r_hold_ll <= '0;
      r_hold_en <= '0;
    end else if (i_sample_valid) begin
      r_prev <= i_sample_in;
      r_seen <= 1'b1;
      if (w_close) begin
        r_hold_ll <= w_ll_sum;
        r_hold_en <= w_en_sum;
        r_ll_acc  <= '0;
        r_en_acc  <= '0;
        r_cnt     <= '0;
      end else begin
        r_ll_acc  <= w_ll_sum;
        r_en_acc  <= w_en_sum;
        r_cnt     <= r_cnt + WIN_LOG2'(1);
      end
    end
  end

  // Emit FSM and output slot: one EMIT cycle per closed window, drop on full slot.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ACCUM;
      r_ll_out    <= '0;
      r_en_out    <= '0;
      r_detect    <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ACCUM: begin
          if (w_close) begin
            r_state <= EMIT;
          end
        end
        EMIT: begin
          r_state <= ACCUM;
          if (w_slot_free) begin
            r_ll_out    <= r_hold_ll;
            r_en_out    <= r_hold_en;
            r_detect    <= (r_hold_ll > i_ll_thresh) && (r_hold_en > i_en_thresh);
            r_out_valid <= 1'b1;
          end else begin
            r_overrun   <= 1'b1;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign o_ll_out    = r_ll_out;
  assign o_en_out    = r_en_out;
  assign o_detect    = r_detect;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_eeg_window_features.sv
// Self-checking bench for eeg_window_features (WIN_LOG2=2, ESHIFT=0).
module tb_eeg_window_features;

  localparam int WIN_LOG2 = 2;
  localparam int ESHIFT   = 0;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int LL_W     = 33 + WIN_LOG2;
  localparam int EN_W     = 64 + WIN_LOG2;

  logic             i_clk;
  logic             i_reset;
  logic [31:0]      i_sample_in;
  logic             i_sample_valid;
  logic [LL_W-1:0]  i_ll_thresh;
  logic [EN_W-1:0]  i_en_thresh;
  logic [LL_W-1:0]  o_ll_out;
  logic [EN_W-1:0]  o_en_out;
  logic             o_detect;
  logic             o_out_valid;
  logic             i_out_ready;
  logic             o_overrun;

  eeg_window_features #(
    .WIN_LOG2 (WIN_LOG2),
    .ESHIFT   (ESHIFT)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_sample_in    (i_sample_in),
    .i_sample_valid (i_sample_valid),
    .i_ll_thresh    (i_ll_thresh),
    .i_en_thresh    (i_en_thresh),
    .o_ll_out       (o_ll_out),
    .o_en_out       (o_en_out),
    .o_detect       (o_detect),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_overrun      (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_res = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Reference model: window sums from plain arithmetic on the sample history.
  typedef struct {
    logic [127:0] ll;
    logic [127:0] en;
    logic         det;
  } res_t;

  res_t         exp_q[$];
  longint       m_prev;
  bit           m_seen;
  int           m_cnt;
  logic [127:0] m_ll;
  logic [127:0] m_en;
  bit           m_keep;

  task automatic m_reset();
    m_prev = 0; m_seen = 0; m_cnt = 0; m_ll = '0; m_en = '0;
    exp_q.delete();
  endtask

  task automatic m_sample(input int x);
    longint d;
    longint sq;
    res_t r;
    d  = m_seen ? (longint'(x) - m_prev) : 64'sd0;
    if (d < 0) d = -d;
    sq = longint'(x) * longint'(x);
    m_ll = m_ll + 128'(d);
    m_en = m_en + (128'(sq) >> ESHIFT);
    m_prev = longint'(x);
    m_seen = 1;
    m_cnt++;
    if (m_cnt == WIN) begin
      r.ll  = m_ll;
      r.en  = m_en;
      r.det = (m_ll > 128'(i_ll_thresh)) && (m_en > 128'(i_en_thresh));
      if (m_keep) exp_q.push_back(r);
      m_cnt = 0; m_ll = '0; m_en = '0;
    end
  endtask

  // Every handshake is checked against the oldest expected result.
  always @(negedge i_clk) begin
    if (i_reset && o_out_valid && i_out_ready) begin
      res_t r;
      n_res++;
      if (exp_q.size() == 0) begin
        check_eq("spurious_result", 1, 0);
      end else begin
        r = exp_q.pop_front();
        check_eq("mon_ll", o_ll_out, r.ll);
        check_eq("mon_en", o_en_out, r.en);
        check_eq("mon_detect", o_detect, r.det);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic send(input int x);
    i_sample_in    = x;
    i_sample_valid = 1'b1;
    @(posedge i_clk); #1;
    i_sample_valid = 1'b0;
    i_sample_in    = $urandom;
    m_sample(x);
  endtask

  task automatic wait_res(output logic [127:0] ll, output logic [127:0] en, output logic det);
    bit got;
    got = 0; ll = '0; en = '0; det = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge i_clk);
      if (o_out_valid) begin
        got = 1; ll = o_ll_out; en = o_en_out; det = o_detect;
      end
    end
    check_eq("result_timeout", got, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, o_out_valid, 0);
    check_eq({tag, "_ll"}, o_ll_out, 0);
    check_eq({tag, "_en"}, o_en_out, 0);
    check_eq({tag, "_detect"}, o_detect, 0);
    check_eq({tag, "_overrun"}, o_overrun, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ll, en;
    logic         det;
    int           n0;
    int           x;

    // Reset with inputs toggling.
    i_reset = 1'b0; i_sample_valid = 1'b0; i_sample_in = '0; i_out_ready = 1'b0;
    i_ll_thresh = '0; i_en_thresh = '0; m_keep = 1;
    m_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge i_clk); #1;
      i_sample_in    = $urandom;
      i_sample_valid = 1'($urandom_range(0, 1));
      i_out_ready    = 1'($urandom_range(0, 1));
      i_ll_thresh    = LL_W'($urandom);
      i_en_thresh    = EN_W'({$urandom, $urandom});
      @(negedge i_clk);
      check_eq("rst_valid", o_out_valid, 0);
    end
    check_all_zero("in_reset");
    @(posedge i_clk); #1;
    i_sample_valid = 1'b0;
    i_reset = 1'b1;
    idle(5);
    check_all_zero("idle");

    // First two windows: latency, values and detect both ways.
    i_out_ready = 1'b1; i_ll_thresh = 12; i_en_thresh = 29;
    send(1); send(3); send(-2); send(4);
    @(negedge i_clk); check_eq("lat_early_valid", o_out_valid, 0);
    @(negedge i_clk);
    check_eq("lat_valid", o_out_valid, 1);
    check_eq("w1_ll", o_ll_out, 13);
    check_eq("w1_en", o_en_out, 30);
    check_eq("w1_detect", o_detect, 1);
    @(negedge i_clk); check_eq("one_cycle_valid", o_out_valid, 0);
    @(posedge i_clk); #1;
    send(4); send(4); send(4); send(4);
    wait_res(ll, en, det);
    check_eq("w2_ll", ll, 0);
    check_eq("w2_en", en, 64);
    check_eq("w2_detect", det, 0);

    // Extreme samples right after reset.
    i_reset = 1'b0; idle(2); i_reset = 1'b1; m_reset();
    send(32'h8000_0000); send(32'h7fff_ffff); send(32'h8000_0000); send(32'h7fff_ffff);
    wait_res(ll, en, det);
    check_eq("ext_ll", ll, 128'd12884901885);
    check_eq("ext_en", en, (128'd1 << 64) - (128'd1 << 33) + 128'd2);

    // Overrun: two windows with no consumer; the second must be dropped.
    i_out_ready = 1'b0;
    for (int k = 0; k < WIN; k++) send(int'($urandom));
    idle(3);
    check_eq("hold_valid", o_out_valid, 1);
    check_eq("hold_ll_a", o_ll_out, exp_q[0].ll);
    m_keep = 0;
    for (int k = 0; k < WIN; k++) send(int'($urandom));
    m_keep = 1;
    idle(3);
    check_eq("held_valid", o_out_valid, 1);
    check_eq("held_ll", o_ll_out, exp_q[0].ll);
    check_eq("held_en", o_en_out, exp_q[0].en);
    check_eq("overrun_set", o_overrun, 1);
    check_eq("one_pending", exp_q.size(), 1);
    i_out_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check_eq("drain_valid", o_out_valid, 0);
    check_eq("overrun_sticky", o_overrun, 1);
    check_eq("drained_after_ovr", exp_q.size(), 0);
    @(posedge i_clk); #1;

    // Reset mid-window discards the partial window.
    send(int'($urandom)); send(int'($urandom));
    i_reset = 1'b0; #1;
    check_all_zero("async_rst");
    m_reset();
    idle(2);
    i_reset = 1'b1;
    n0 = n_res;
    send(1); send(1); send(1); send(1);
    wait_res(ll, en, det);
    check_eq("rst_win_ll", ll, 0);
    check_eq("rst_win_en", en, 4);
    idle(6);
    check_eq("rst_win_count", n_res - n0, 1);

    // Randomized windows, gaps including back-to-back across window edges.
    i_out_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      idle(3);
      if (b % 2 == 0) begin
        i_ll_thresh = LL_W'($urandom_range(0, 8000));
        i_en_thresh = EN_W'($urandom_range(0, 4000000));
      end else begin
        i_ll_thresh = LL_W'({3'($urandom_range(0, 7)), $urandom});
        i_en_thresh = EN_W'({2'($urandom_range(0, 3)), $urandom, $urandom});
      end
      for (int w = 0; w < 8; w++) begin
        for (int k = 0; k < WIN; k++) begin
          idle($urandom_range(0, 2));
          if (b % 2 == 0) x = int'($urandom_range(0, 2000)) - 1000;
          else            x = int'($urandom);
          send(x);
        end
      end
    end
    idle(6);
    check_eq("final_drained", exp_q.size(), 0);
    check_eq("final_overrun", o_overrun, 0);
    check_eq("final_valid", o_out_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
